lcd_text_buffer: RTL



---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_text_ram.sv | 43 ++++
 rtl/lcd_text_buffer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the LCD1602 text buffer.
// Scroll states exist only when LCD_TB_SCROLL_EN is defined.
package lcd_pkg;

  localparam int LCD_COLS  = 16;
  localparam int LCD_CELLS = 32;
  localparam int ADDR_W    = $clog2(LCD_CELLS);

  // Control codes understood by the buffer; all other codes below 0x20 are dropped.
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  // Lowest byte value that is stored as a character.
  localparam logic [7:0] PRINT_MIN = 8'h20;

  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(LCD_CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(LCD_COLS - 1);
  localparam logic [ADDR_W-1:0] LINE2_BASE = ADDR_W'(LCD_COLS);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CLEAR       = 2'd1
`ifdef LCD_TB_SCROLL_EN
    ,
    SCROLL_CP   = 2'd2,
    SCROLL_FILL = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/lcd_text_ram.sv
// 32x8 screen storage: one write port, one registered read port for the LCD
// controller and, when LCD_TB_SCROLL_EN is defined, one combinational read
// port used to copy line 2 onto line 1.
module lcd_text_ram
  import lcd_pkg::*;
#(
  parameter logic [7:0] CLR_CHAR = 8'h20
) (
  input  logic              C,
  input  logic              R,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
`ifdef LCD_TB_SCROLL_EN
  ,
  input  logic [ADDR_W-1:0] cp_addr,
  output logic [7:0]        cp_data
`endif
);

  logic [7:0] mem [LCD_CELLS];

  // Cell write.
  // NOTE: the array has no reset branch; the CLEAR sequence initialises it,
  // which keeps it mappable onto plain RAM. Non-blocking assignment also gives
  // read-before-write on the registered read port below.
  always_ff @(posedge C) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read for the LCD controller; returns the pre-write value on a collision.
  always_ff @(posedge C) begin
    if (R) rd_data <= CLR_CHAR;
    else   rd_data <= mem[rd_addr];
  end

`ifdef LCD_TB_SCROLL_EN
  assign cp_data = mem[cp_addr];
`endif

endmodule

// File: rtl/lcd_text_buffer.sv
// Text buffer feeding the LCD1602 controller: accepts a byte stream, keeps a
// cursor and writes characters into a 32-cell screen image.
// Optional feature: define LCD_TB_SCROLL_EN to scroll line 2 up instead of
// wrapping the cursor to cell 0.
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter logic [7:0] CLR_CHAR = 8'h20
) (
  input  logic              C,
  input  logic              R,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy,
  output logic              upd
);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   idx, idx_nx;       // cell counter for clear / scroll sequences
  logic [ADDR_W-1:0]   cursor_nx;
  logic                upd_nx;
  logic                wrap;
  logic                accept;
  logic                we;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          wr_data;
`ifdef LCD_TB_SCROLL_EN
  logic [ADDR_W-1:0]   cp_addr;
  logic [7:0]          cp_data;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  // State, counter, cursor and completion pulse registers.
  always_ff @(posedge C) begin
    if (R) begin
      state  <= CLEAR;
      idx    <= '0;
      cursor <= '0;
      upd    <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cursor <= cursor_nx;
      upd    <= upd_nx;
    end
  end

  // Next-state, cursor update and buffer write-port control.
  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cursor_nx = cursor;
    upd_nx    = 1'b0;
    wrap      = 1'b0;
    we        = 1'b0;
    wr_addr   = idx;
    wr_data   = CLR_CHAR;
`ifdef LCD_TB_SCROLL_EN
    cp_addr   = LINE2_BASE + ADDR_W'(idx[3:0]);
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          if (in_data >= PRINT_MIN) begin
            we      = 1'b1;
            wr_addr = cursor;
            wr_data = in_data;
            upd_nx  = 1'b1;
            if (cursor == LAST_CELL) wrap = 1'b1;
            else                     cursor_nx = cursor + 1'b1;
          end else begin
            case (in_data)
              CC_LF: begin
                if (!cursor[4]) cursor_nx = LINE2_BASE;
                else            wrap = 1'b1;
              end
              CC_CR: cursor_nx = {cursor[4], 4'b0000};
              CC_BS: begin
                if (cursor != '0) begin
                  cursor_nx = cursor - 1'b1;
                  we        = 1'b1;
                  wr_addr   = cursor - 1'b1;
                  upd_nx    = 1'b1;
                end
              end
              CC_FF: begin
                state_nx = CLEAR;
                idx_nx   = '0;
              end
              default: ;  // other control codes are consumed silently
            endcase
          end
        end
      end

      CLEAR: begin
        we     = 1'b1;
        idx_nx = idx + 1'b1;
        if (idx == LAST_CELL) begin
          state_nx  = IDLE;
          cursor_nx = '0;
          upd_nx    = 1'b1;
        end
      end

`ifdef LCD_TB_SCROLL_EN
      SCROLL_CP: begin
        we      = 1'b1;
        wr_data = cp_data;
        idx_nx  = idx + 1'b1;
        if (idx == LAST_COL) state_nx = SCROLL_FILL;
      end

      SCROLL_FILL: begin
        we     = 1'b1;
        idx_nx = idx + 1'b1;
        if (idx == LAST_CELL) begin
          state_nx  = IDLE;
          cursor_nx = LINE2_BASE;
          upd_nx    = 1'b1;
        end
      end
`endif

      default: begin
        state_nx = CLEAR;
        idx_nx   = '0;
      end
    endcase

    // Cursor ran past the last cell: scroll line 2 up, or restart at cell 0.
    if (wrap) begin
`ifdef LCD_TB_SCROLL_EN
      state_nx = SCROLL_CP;
      idx_nx   = '0;
      upd_nx   = 1'b0;
`else
      cursor_nx = '0;
`endif
    end
  end

  lcd_text_ram #(
    .CLR_CHAR (CLR_CHAR)
  ) u_ram (
    .C       (C),
    .R       (R),
    .we      (we & ~R),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`ifdef LCD_TB_SCROLL_EN
    ,
    .cp_addr (cp_addr),
    .cp_data (cp_data)
`endif
  );

endmodule
